// File: rtl/button_event_pkg.sv
`default_nettype none
// ============================================================================
// Module   : button_event_pkg
// Purpose  : Shared definitions for the button event controller: default
//            parameter values, the event-kind encoding produced by the shared
//            key evaluator, and a counter-width helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package button_event_pkg;

    localparam int c_DEF_N_KEYS     = 4;
    localparam int c_DEF_TICK_DIV   = 50000;
    localparam int c_DEF_STABLE_CNT = 3;
    localparam int c_DEF_LONG_CNT   = 200;

    // Outcome of servicing one key on a scan tick.
    typedef enum logic [1:0] {
        EVT_NONE    = 2'd0,
        EVT_PRESS   = 2'd1,
        EVT_RELEASE = 2'd2,
        EVT_LONG    = 2'd3
    } evt_kind_t;

    // Bits needed to hold values 0..max_val; never narrower than one bit so
    // degenerate ranges (max_val == 0) still produce a legal vector.
    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/button_event_ctrl_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : tick_gen
// Purpose  : Free-running prescaler. Counts 0..DIV-1 and wraps; tick is high
//            for exactly the one cycle in which the count equals DIV-1.
// Ports    : clk   - system clock (rising edge)
//            reset - synchronous active-high reset, clears the count
//            tick  - one-cycle strobe every DIV cycles
// Revision : 1.0 - initial release
// ============================================================================
module tick_gen
    import button_event_pkg::*;
#(
    parameter int DIV = c_DEF_TICK_DIV
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int              c_W    = cnt_width(DIV - 1);
    localparam logic [c_W-1:0]  c_LAST = c_W'(DIV - 1);

    logic [c_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (r_count == c_LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    // Decoded straight from the count so the first tick after reset lands
    // DIV cycles after release (count 0 occupies the first cycle).
    assign tick = (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/button_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : button_event_ctrl
// Purpose  : Debounces N_KEYS active-low push buttons with a single shared
//            evaluator that services one key per prescaler tick in round-robin
//            order, and reports press, release and long-press events.
// Ports    : clk          - system clock (rising edge)
//            reset        - synchronous active-high reset
//            btn_n        - raw asynchronous buttons, 0 = pressed
//            pressed      - debounced level per key, 1 = pressed
//            press_evt    - one-cycle pulse on an accepted press
//            release_evt  - one-cycle pulse on an accepted release
//            long_evt     - one-cycle pulse once a press is held LONG_CNT
//                           services
// Revision : 1.0 - initial release
// ============================================================================
module button_event_ctrl
    import button_event_pkg::*;
#(
    parameter int N_KEYS     = c_DEF_N_KEYS,
    parameter int TICK_DIV   = c_DEF_TICK_DIV,
    parameter int STABLE_CNT = c_DEF_STABLE_CNT,
    parameter int LONG_CNT   = c_DEF_LONG_CNT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_KEYS-1:0] btn_n,
    output logic [N_KEYS-1:0] pressed,
    output logic [N_KEYS-1:0] press_evt,
    output logic [N_KEYS-1:0] release_evt,
    output logic [N_KEYS-1:0] long_evt
);

    localparam int c_IDX_W  = cnt_width(N_KEYS - 1);
    localparam int c_CNT_W  = cnt_width(STABLE_CNT - 1);
    localparam int c_HOLD_W = cnt_width(LONG_CNT);

    localparam logic [c_IDX_W-1:0]  c_IDX_LAST = c_IDX_W'(N_KEYS - 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_LAST = c_CNT_W'(STABLE_CNT - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_MAX = c_HOLD_W'(LONG_CNT);
    localparam logic [c_HOLD_W-1:0] c_HOLD_PRE = c_HOLD_W'(LONG_CNT - 1);

    // ------------------------------------------------------------------
    // Two-flop synchronizer; idles at 1 (released) out of reset.
    // ------------------------------------------------------------------
    logic [N_KEYS-1:0] r_sync1;
    logic [N_KEYS-1:0] r_sync2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= btn_n;
            r_sync2 <= r_sync1;
        end
    end

    // ------------------------------------------------------------------
    // Scan tick and round-robin key index.
    // ------------------------------------------------------------------
    logic               w_tick;
    logic [c_IDX_W-1:0] r_scan_idx;

    tick_gen #(
        .DIV   (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (w_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_scan_idx <= '0;
        end else if (w_tick) begin
            if (r_scan_idx == c_IDX_LAST) begin
                r_scan_idx <= '0;
            end else begin
                r_scan_idx <= r_scan_idx + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-key state. Only the entry addressed by r_scan_idx changes on a
    // tick; every other key simply holds.
    // ------------------------------------------------------------------
    logic [N_KEYS-1:0]   r_db;                 // debounced level, 1 = released
    logic [c_CNT_W-1:0]  r_cnt  [N_KEYS];      // consecutive differing samples
    logic [c_HOLD_W-1:0] r_hold [N_KEYS];      // services spent pressed

    // ------------------------------------------------------------------
    // Shared evaluator: one copy of the debounce/hold logic, fed by a mux
    // on r_scan_idx.
    // ------------------------------------------------------------------
    logic                w_sync_sel;
    logic                w_db_sel;
    logic [c_CNT_W-1:0]  w_cnt_sel;
    logic [c_HOLD_W-1:0] w_hold_sel;
    logic                w_db_nxt;
    logic [c_CNT_W-1:0]  w_cnt_nxt;
    logic [c_HOLD_W-1:0] w_hold_nxt;
    evt_kind_t           w_evt;

    assign w_sync_sel = r_sync2[r_scan_idx];
    assign w_db_sel   = r_db[r_scan_idx];
    assign w_cnt_sel  = r_cnt[r_scan_idx];
    assign w_hold_sel = r_hold[r_scan_idx];

    always_comb begin
        w_db_nxt   = w_db_sel;
        w_cnt_nxt  = w_cnt_sel;
        w_hold_nxt = w_hold_sel;
        w_evt      = EVT_NONE;

        // Debounce: a level change is accepted only after STABLE_CNT
        // consecutive services disagree with the current debounced level.
        if (w_sync_sel == w_db_sel) begin
            w_cnt_nxt = '0;
        end else if (w_cnt_sel < c_CNT_LAST) begin
            w_cnt_nxt = w_cnt_sel + 1'b1;
        end else begin
            w_db_nxt  = w_sync_sel;
            w_cnt_nxt = '0;
            w_evt     = w_sync_sel ? EVT_RELEASE : EVT_PRESS;
        end

        // Hold tracking runs on the pre-service level, so the service that
        // accepts a press leaves hold at 0 and counting starts on the next
        // one. Saturation at LONG_CNT makes the long event fire only once.
        if (w_db_sel || (w_evt == EVT_RELEASE)) begin
            w_hold_nxt = '0;
        end else if (w_hold_sel != c_HOLD_MAX) begin
            w_hold_nxt = w_hold_sel + 1'b1;
            if (w_hold_sel == c_HOLD_PRE) begin
                w_evt = EVT_LONG;
            end
        end
    end

    // ------------------------------------------------------------------
    // State write-back and registered event pulses.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_db        <= '1;
            press_evt   <= '0;
            release_evt <= '0;
            long_evt    <= '0;
            for (int k = 0; k < N_KEYS; k++) begin
                r_cnt[k]  <= '0;
                r_hold[k] <= '0;
            end
        end else begin
            press_evt   <= '0;
            release_evt <= '0;
            long_evt    <= '0;
            if (w_tick) begin
                r_db[r_scan_idx]   <= w_db_nxt;
                r_cnt[r_scan_idx]  <= w_cnt_nxt;
                r_hold[r_scan_idx] <= w_hold_nxt;
                case (w_evt)
                    EVT_PRESS:   press_evt[r_scan_idx]   <= 1'b1;
                    EVT_RELEASE: release_evt[r_scan_idx] <= 1'b1;
                    EVT_LONG:    long_evt[r_scan_idx]    <= 1'b1;
                    default:     ;
                endcase
            end
        end
    end

    // Derived from the debounced register, so it changes on the same edge
    // that launches the corresponding event pulse.
    assign pressed = ~r_db;

endmodule
`default_nettype wire

// File: tb/tb_button_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_event_ctrl
// Purpose  : Directed self-checking bench for button_event_ctrl with
//            N_KEYS=4, TICK_DIV=4, STABLE_CNT=3, LONG_CNT=5. Key i is serviced
//            on the tick in cycle 16k+4i+3 after reset release; results are
//            visible the following cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_event_ctrl;

    localparam int c_N_KEYS     = 4;
    localparam int c_TICK_DIV   = 4;
    localparam int c_STABLE_CNT = 3;
    localparam int c_LONG_CNT   = 5;

    logic                clk;
    logic                reset;
    logic [c_N_KEYS-1:0] btn_n;
    logic [c_N_KEYS-1:0] pressed;
    logic [c_N_KEYS-1:0] press_evt;
    logic [c_N_KEYS-1:0] release_evt;
    logic [c_N_KEYS-1:0] long_evt;

    int total;
    int bad;
    int cyc;
    int n_press   [c_N_KEYS];
    int n_release [c_N_KEYS];
    int n_long    [c_N_KEYS];

    button_event_ctrl #(
        .N_KEYS      (c_N_KEYS),
        .TICK_DIV    (c_TICK_DIV),
        .STABLE_CNT  (c_STABLE_CNT),
        .LONG_CNT    (c_LONG_CNT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_n       (btn_n),
        .pressed     (pressed),
        .press_evt   (press_evt),
        .release_evt (release_evt),
        .long_evt    (long_evt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle index relative to the last edge at which reset was sampled high.
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Event pulse tallies, sampled mid-cycle.
    always @(negedge clk) begin
        for (int k = 0; k < c_N_KEYS; k++) begin
            if (reset) begin
                n_press[k]   <= 0;
                n_release[k] <= 0;
                n_long[k]    <= 0;
            end else begin
                n_press[k]   <= n_press[k]   + (press_evt[k]   ? 1 : 0);
                n_release[k] <= n_release[k] + (release_evt[k] ? 1 : 0);
                n_long[k]    <= n_long[k]    + (long_evt[k]    ? 1 : 0);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance to 1 time unit after the edge that starts cycle c.
    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input logic [c_N_KEYS-1:0] b);
        reset = 1'b1;
        btn_n = b;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        btn_n = '1;

        // ---------------- idle: no buttons for 100 cycles ----------------
        do_reset(4'hF);
        check("rst_pressed", 32'(pressed), 32'h0);
        check("rst_events", 32'({press_evt, release_evt, long_evt}), 32'h0);
        goto(100);
        check("idle_pressed", 32'(pressed), 32'h0);
        check("idle_evt_cnt", 32'(n_press[0] + n_press[1] + n_press[2] + n_press[3]
                                 + n_release[0] + n_release[1] + n_release[2] + n_release[3]
                                 + n_long[0] + n_long[1] + n_long[2] + n_long[3]), 32'h0);

        // -------- keys 0,1,2 pressed from cycle 0; key 1 bounces ---------
        do_reset(4'b1000);
        goto(24);
        check("k1_cnt_after2", 32'(dut.r_cnt[1]), 32'd2);
        btn_n[1] = 1'b1;                      // release before 3rd service
        goto(36);
        check("k0_press", 32'(press_evt), 32'b0001);
        check("k0_pressed", 32'(pressed), 32'b0001);
        goto(40);
        check("k1_cnt_cleared", 32'(dut.r_cnt[1]), 32'd0);
        btn_n[1] = 1'b0;                      // fresh press of key 1
        goto(43);
        check("k2_before", 32'(press_evt), 32'h0);
        check("k2_pressed_before", 32'(pressed), 32'b0001);
        goto(44);
        check("k2_press", 32'(press_evt), 32'b0100);
        check("k2_pressed", 32'(pressed), 32'b0101);
        goto(45);
        check("k2_press_1cyc", 32'(press_evt), 32'h0);
        goto(56);
        check("k1_no_early", 32'(press_evt), 32'h0);
        goto(88);
        check("k1_press", 32'(press_evt), 32'b0010);
        check("k1_pressed", 32'(pressed), 32'b0111);
        goto(115);
        check("k0_long_before", 32'(long_evt), 32'h0);
        goto(116);
        check("k0_long", 32'(long_evt), 32'b0001);
        goto(117);
        check("k0_long_1cyc", 32'(long_evt), 32'h0);
        goto(124);
        check("k2_long", 32'(long_evt), 32'b0100);
        goto(200);
        check("k0_long_once", 32'(n_long[0]), 32'd1);
        btn_n[0] = 1'b1;                      // release key 0
        goto(243);
        check("k0_held", 32'(pressed), 32'b0111);
        goto(244);
        check("k0_release", 32'(release_evt), 32'b0001);
        check("k0_released", 32'(pressed), 32'b0110);
        check("k0_hold_clr", 32'(dut.r_hold[0]), 32'd0);
        goto(250);
        btn_n[0] = 1'b0;                      // press key 0 again
        goto(292);
        check("k0_repress", 32'(press_evt), 32'b0001);
        goto(371);
        check("k0_long2_before", 32'(long_evt), 32'h0);
        goto(372);
        check("k0_long2", 32'(long_evt), 32'b0001);
        goto(380);
        check("k0_n_press", 32'(n_press[0]), 32'd2);
        check("k0_n_release", 32'(n_release[0]), 32'd1);
        check("k0_n_long", 32'(n_long[0]), 32'd2);
        check("k1_n_press", 32'(n_press[1]), 32'd1);

        // ---------------- reset in the middle of debouncing key 3 ----------
        do_reset(4'b0111);
        goto(16);
        check("k3_cnt1", 32'(dut.r_cnt[3]), 32'd1);
        goto(40);
        check("k3_cnt2", 32'(dut.r_cnt[3]), 32'd2);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_events", 32'({press_evt, release_evt, long_evt}), 32'h0);
        check("mid_rst_cnt", 32'(dut.r_cnt[3]), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("post_rst_events", 32'({press_evt, release_evt, long_evt}), 32'h0);
        goto(1);
        check("post_rst_events1", 32'({press_evt, release_evt, long_evt}), 32'h0);
        goto(32);
        check("k3_no_early", 32'(press_evt), 32'h0);
        goto(47);
        check("k3_before", 32'(press_evt), 32'h0);
        goto(48);
        check("k3_press", 32'(press_evt), 32'b1000);
        check("k3_pressed", 32'(pressed), 32'b1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/button_event_ctrl.md
BUTTON_EVENT_CTRL -- requirements
Module: button_event_ctrl

Interface
REQ-001 The block SHALL have parameter N_KEYS, default 4, number of active-low buttons (2..16).
REQ-002 The block SHALL have parameter TICK_DIV, default 50000, clk cycles per scan tick (>=2).
REQ-003 The block SHALL have parameter STABLE_CNT, default 3, consecutive differing samples required to accept a level change (>=1).
REQ-004 The block SHALL have parameter LONG_CNT, default 200, services of a held key before long-press (>=STABLE_CNT).
REQ-005 clk  in  1  single system clock; all logic on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 btn_n  in  N_KEYS  raw asynchronous buttons, 0 = pressed.
REQ-008 pressed  out  N_KEYS  debounced level per key, 1 = pressed.
REQ-009 press_evt  out  N_KEYS  one-cycle pulse on accepted press; at most one bit set per cycle.
REQ-010 release_evt  out  N_KEYS  one-cycle pulse on accepted release; at most one bit set per cycle.
REQ-011 long_evt  out  N_KEYS  one-cycle pulse when a press has been held LONG_CNT services; at most one bit set per cycle.

Function
REQ-012 Each btn_n bit SHALL pass through a 2-flop synchronizer before use; sync flops reset to 1.
REQ-013 Prescaler SHALL count 0..TICK_DIV-1 and wrap; tick asserts for one cycle when count == TICK_DIV-1.
REQ-014 A shared evaluator SHALL service exactly one key per tick, index scan_idx, which increments after each tick and wraps N_KEYS-1 -> 0; each key is serviced every N_KEYS*TICK_DIV cycles.
REQ-015 Per-key state: debounced level db (1 = released), stability counter cnt, hold counter hold.
REQ-016 On service, if sync == db: cnt <= 0.
REQ-017 On service, if sync != db and cnt < STABLE_CNT-1: cnt <= cnt+1.
REQ-018 On service, if sync != db and cnt == STABLE_CNT-1: db <= sync, cnt <= 0, and press_evt[i] (sync=0) or release_evt[i] (sync=1) SHALL pulse the cycle after the tick.
REQ-019 pressed[i] SHALL equal ~db[i] and update in the same cycle as the event pulse.
REQ-020 While db==0 on service, hold SHALL increment, saturating at LONG_CNT; the transition to LONG_CNT SHALL pulse long_evt[i] once, the cycle after the tick.
REQ-021 hold SHALL clear to 0 on the service that accepts a release and whenever db==1.
REQ-022 Any mismatch shorter than STABLE_CNT consecutive services (bounce) SHALL produce no event and no pressed change.
REQ-023 Unserviced keys SHALL hold all state; raw activity between services is ignored.
REQ-024 Counter widths SHALL be $clog2 of their maximum value + 1; no counter SHALL wrap.

Reset
REQ-025 With reset high at a clk edge: prescaler=0, scan_idx=0, all db=1, cnt=0, hold=0, sync flops=1, pressed=0, all event outputs=0.
REQ-026 Reset mid-debounce or mid-hold SHALL discard progress; no event SHALL be emitted in the cycle reset is asserted or the cycle after.
REQ-027 After reset release, the first tick SHALL occur TICK_DIV cycles later and service key 0.

Structure
REQ-028 Package button_event_pkg SHALL hold the default parameter values and the event-kind enum (EVT_NONE, EVT_PRESS, EVT_RELEASE, EVT_LONG).
REQ-029 The prescaler SHALL be a sub-module tick_gen (parameter DIV; ports clk, reset, tick).
REQ-030 Evaluator logic SHALL be one shared instance muxed by scan_idx, not replicated per key.

Verification (N_KEYS=4, TICK_DIV=4, STABLE_CNT=3, LONG_CNT=5; key i serviced at cycles 4*(4k+i)+3 after reset release)
REQ-031 Reset, btn_n=4'hF for 100 cycles -> pressed=0, no event pulses.
REQ-032 btn_n[2]=0 held from cycle 0 -> press_evt=4'b0100 for one cycle after the 3rd service of key 2 (tick at cycle 43, pulse at cycle 44); pressed[2]=1 thereafter.
REQ-033 btn_n[1] low for 2 services then high -> no press_evt, pressed[1] stays 0, cnt[1] returns to 0.
REQ-034 Hold btn_n[0] low continuously -> press_evt[0] once, long_evt[0] exactly once 5 services later, none after.
REQ-035 Release key 0 after long press -> release_evt[0] after 3 services; a fresh press restarts hold so long_evt can fire again.
REQ-036 Assert reset while key 3 cnt=2 -> after release, key 3 requires 3 fresh services to emit press_evt[3].
